// File: rtl/spi_bus_arbiter.sv
// Two-master whole-transaction arbiter in front of the SPI controller handshake port.
// Define SPI_BUS_ARB_STICKY_EN to let an owner keep the grant across back-to-back transactions.
module spi_bus_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_BURST   = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_rd_i,
  input  logic        m0_wr_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_rd_i,
  input  logic        m1_wr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_data_o,
  output logic        bus_hs_rd_o,
  output logic        bus_hs_wr_o,
  output logic [31:0] bus_hs_addr_o,
  output logic [31:0] bus_hs_data_o,
  input  logic        bus_hs_ready_i,
  input  logic [31:0] bus_hs_data_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_hold_range
    $error("spi_bus_arbiter: HOLD_CYCLES must be 1..15");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_burst_range
    $error("spi_bus_arbiter: MAX_BURST must be 1..255");
  end

  state_t state;
  logic   owner;
  logic   last_owner;
  logic   m0_req;
  logic   m1_req;
  logic   owner_req;

`ifdef SPI_BUS_ARB_STICKY_EN
  logic [3:0] hold_cnt;
  logic [7:0] burst_cnt;
  logic [8:0] burst_next;

  assign burst_next = {1'b0, burst_cnt} + 9'd1;
`endif

  assign m0_req    = m0_rd_i | m0_wr_i;
  assign m1_req    = m1_rd_i | m1_wr_i;
  assign owner_req = owner ? m1_req : m0_req;

  // Only the owner sees the bus, and only while a transaction is in flight; wr beats rd.
  always_comb begin
    bus_hs_rd_o   = 1'b0;
    bus_hs_wr_o   = 1'b0;
    bus_hs_addr_o = '0;
    bus_hs_data_o = '0;
    m0_ready_o    = 1'b0;
    m0_data_o     = '0;
    m1_ready_o    = 1'b0;
    m1_data_o     = '0;
    if (state == BUSY) begin
      if (owner) begin
        bus_hs_wr_o   = m1_wr_i;
        bus_hs_rd_o   = m1_rd_i & ~m1_wr_i;
        bus_hs_addr_o = m1_addr_i;
        bus_hs_data_o = m1_data_i;
        m1_ready_o    = bus_hs_ready_i;
        m1_data_o     = bus_hs_data_i;
      end else begin
        bus_hs_wr_o   = m0_wr_i;
        bus_hs_rd_o   = m0_rd_i & ~m0_wr_i;
        bus_hs_addr_o = m0_addr_i;
        bus_hs_data_o = m0_data_i;
        m0_ready_o    = bus_hs_ready_i;
        m0_data_o     = bus_hs_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
`ifdef SPI_BUS_ARB_STICKY_EN
      hold_cnt   <= '0;
      burst_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner <= (m0_req && m1_req) ? ~last_owner : m1_req;
            state <= BUSY;
`ifdef SPI_BUS_ARB_STICKY_EN
            burst_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus_hs_ready_i) begin
`ifdef SPI_BUS_ARB_STICKY_EN
            burst_cnt <= burst_next[7:0];
            if (burst_next < 9'(MAX_BURST)) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end else begin
              state      <= IDLE;
              last_owner <= owner;
            end
`else
            state      <= IDLE;
            last_owner <= owner;
`endif
          end else if (!owner_req) begin
            // Owner abandoned its request mid-transaction: release without a ready.
            state      <= IDLE;
            last_owner <= owner;
          end
        end
        HOLD: begin
`ifdef SPI_BUS_ARB_STICKY_EN
          if (owner_req) begin
            state <= BUSY;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
            if (hold_cnt == 4'(HOLD_CYCLES - 1)) begin
              state      <= IDLE;
              last_owner <= owner;
            end
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter; expectations follow SPI_BUS_ARB_STICKY_EN when defined.
module tb_spi_bus_arbiter;

  localparam int HOLD = 4;
  localparam int MAXB = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        m0_rd_i = 1'b0, m0_wr_i = 1'b0, m1_rd_i = 1'b0, m1_wr_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m0_data_i = '0, m1_addr_i = '0, m1_data_i = '0;
  logic        m0_ready_o, m1_ready_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        bus_hs_rd_o, bus_hs_wr_o;
  logic [31:0] bus_hs_addr_o, bus_hs_data_o;
  logic        bus_hs_ready_i = 1'b0;
  logic [31:0] bus_hs_data_i = '0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    int          master;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;
    int          lat;
  } exp_t;

  txn_t q0[$];
  txn_t q1[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat_cfg = 1;
  int   last_done = 0;
  int   req_cyc0 = 0;
  int   req_cyc1 = 0;

  spi_bus_arbiter #(.HOLD_CYCLES(HOLD), .MAX_BURST(MAXB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_rd_i(m0_rd_i), .m0_wr_i(m0_wr_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m0_ready_o(m0_ready_o), .m0_data_o(m0_data_o),
    .m1_rd_i(m1_rd_i), .m1_wr_i(m1_wr_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m1_ready_o(m1_ready_o), .m1_data_o(m1_data_o),
    .bus_hs_rd_o(bus_hs_rd_o), .bus_hs_wr_o(bus_hs_wr_o),
    .bus_hs_addr_o(bus_hs_addr_o), .bus_hs_data_o(bus_hs_data_o),
    .bus_hs_ready_i(bus_hs_ready_i), .bus_hs_data_i(bus_hs_data_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] rdVal(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue a transaction on a master and its expected completion, in expected grant order.
  task automatic applyStimulus(input int m, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input int gap, input int lat);
    txn_t t;
    exp_t e;
    t.wr = wr; t.addr = addr; t.data = data;
    if (m == 0) q0.push_back(t); else q1.push_back(t);
    e.master = m; e.wr = wr; e.addr = addr; e.data = wr ? data : rdVal(addr);
    e.gap = gap; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    checkOutput(tag, 32'(sb.size()), 32'd0);
    repeat (12) @(posedge clk_i);
    #4;
    checkOutput({tag, "_idle"}, 32'({bus_hs_rd_o, bus_hs_wr_o, m0_ready_o, m1_ready_o}), 32'd0);
  endtask

  // Masters: drive at +1 after the edge, hold until their ready is seen, then take the next job.
  initial begin : masters
    txn_t t;
    bit act0 = 0, act1 = 0, seen0 = 0, seen1 = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_i) begin
        q0.delete(); q1.delete();
        act0 = 0; act1 = 0; seen0 = 0; seen1 = 0;
      end
      if (act0 && seen0) act0 = 0;
      if (!act0 && q0.size() > 0) begin
        t = q0.pop_front();
        m0_wr_i = t.wr; m0_rd_i = !t.wr; m0_addr_i = t.addr; m0_data_i = t.wr ? t.data : 32'd0;
        act0 = 1; req_cyc0 = cyc;
      end
      if (!act0) begin
        m0_wr_i = 0; m0_rd_i = 0; m0_addr_i = '0; m0_data_i = '0;
      end
      if (act1 && seen1) act1 = 0;
      if (!act1 && q1.size() > 0) begin
        t = q1.pop_front();
        m1_wr_i = t.wr; m1_rd_i = !t.wr; m1_addr_i = t.addr; m1_data_i = t.wr ? t.data : 32'd0;
        act1 = 1; req_cyc1 = cyc;
      end
      if (!act1) begin
        m1_wr_i = 0; m1_rd_i = 0; m1_addr_i = '0; m1_data_i = '0;
      end
      #2;
      seen0 = m0_ready_o;
      seen1 = m1_ready_o;
    end
  end

  // Interconnect model: ready on the lat_cfg-th cycle a request is visible.
  initial begin : responder
    int w = 0;
    forever begin
      @(posedge clk_i);
      #2;
      if (rst_i && (bus_hs_rd_o || bus_hs_wr_o)) begin
        w++;
        if (w >= lat_cfg) begin
          bus_hs_ready_i = 1;
          bus_hs_data_i  = bus_hs_wr_o ? 32'hDEAD_BEEF : rdVal(bus_hs_addr_o);
          w = 0;
        end else begin
          bus_hs_ready_i = 0;
          bus_hs_data_i  = '0;
        end
      end else begin
        w = 0;
        bus_hs_ready_i = 0;
        bus_hs_data_i  = '0;
      end
    end
  end

  initial begin : monitor
    bit   prev = 0;
    bit   act;
    exp_t e;
    forever begin
      @(posedge clk_i);
      #3;
      if (!rst_i) begin
        prev = 0;
      end else begin
        act = bus_hs_rd_o | bus_hs_wr_o;
        if (act && !prev && sb.size() > 0) begin
          if (sb[0].gap > 0) checkOutput("grant_gap", 32'(cyc - last_done), 32'(sb[0].gap));
          if (sb[0].lat > 0)
            checkOutput("grant_latency", 32'(cyc - (sb[0].master == 1 ? req_cyc1 : req_cyc0)),
                        32'(sb[0].lat));
        end
        if (act && bus_hs_ready_i) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            checkOutput("ready_owner", 32'({m1_ready_o, m0_ready_o}),
                        e.master == 1 ? 32'd2 : 32'd1);
            checkOutput("bus_addr", bus_hs_addr_o, e.addr);
            checkOutput("bus_rdwr", 32'({bus_hs_rd_o, bus_hs_wr_o}), e.wr ? 32'd1 : 32'd2);
            if (e.wr) checkOutput("bus_wdata", bus_hs_data_o, e.data);
            else      checkOutput("rdata", e.master == 1 ? m1_data_o : m0_data_o, e.data);
            checkOutput("other_data", e.master == 1 ? m0_data_o : m1_data_o, 32'd0);
          end
          last_done = cyc;
        end else begin
          checkOutput("ready_idle", 32'({m1_ready_o, m0_ready_o}), 32'd0);
        end
        prev = act;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(posedge clk_i);
    #4;
    checkOutput("reset_ctrl", 32'({bus_hs_rd_o, bus_hs_wr_o, m0_ready_o, m1_ready_o}), 32'd0);
    checkOutput("reset_addr", bus_hs_addr_o, 32'd0);
    rst_i = 1;
    @(posedge clk_i);
    #4;

    // Tie straight after reset: master 0 first.
    lat_cfg = 1;
`ifdef SPI_BUS_ARB_STICKY_EN
    applyStimulus(0, 0, 32'h0006_0000, 0, 0, 1);
    applyStimulus(0, 0, 32'h0006_000C, 0, 2, 0);
    applyStimulus(1, 0, 32'h0006_0004, 0, HOLD + 2, 0);
    applyStimulus(1, 0, 32'h0006_0010, 0, 2, 0);
`else
    applyStimulus(0, 0, 32'h0006_0000, 0, 0, 1);
    applyStimulus(1, 0, 32'h0006_0004, 0, 2, 0);
    applyStimulus(0, 0, 32'h0006_000C, 0, 2, 0);
    applyStimulus(1, 0, 32'h0006_0010, 0, 2, 0);
`endif
    waitDrain("tie_drain", 100);

    // Nine back-to-back m0 writes with m1 pending; m1 was last served, so m0 wins the tie.
`ifdef SPI_BUS_ARB_STICKY_EN
    for (int i = 0; i < MAXB; i++)
      applyStimulus(0, 1, 32'h0006_0008, 32'(i + 1), i == 0 ? 0 : 2, i == 0 ? 1 : 0);
    applyStimulus(1, 0, 32'h0006_0000, 0, 2, 0);
    for (int i = MAXB; i < 9; i++)
      applyStimulus(0, 1, 32'h0006_0008, 32'(i + 1), i == MAXB ? HOLD + 2 : 2, 0);
`else
    applyStimulus(0, 1, 32'h0006_0008, 32'd1, 0, 1);
    applyStimulus(1, 0, 32'h0006_0000, 0, 2, 0);
    for (int i = 1; i < 9; i++)
      applyStimulus(0, 1, 32'h0006_0008, 32'(i + 1), 2, 0);
`endif
    waitDrain("burst_drain", 300);

    // Single m0 write, interconnect answers on the third bus cycle.
    lat_cfg = 3;
    applyStimulus(0, 1, 32'h0006_0000, 32'h0000_0004, 0, 1);
    waitDrain("write_drain", 50);

    // Reset in the middle of a BUSY transaction.
    lat_cfg = 6;
    applyStimulus(0, 1, 32'h0006_0004, 32'h0000_0055, 0, 1);
    n = 0;
    while (!bus_hs_wr_o && n < 10) begin
      @(posedge clk_i);
      #4;
      n++;
    end
    checkOutput("midrst_busy", 32'(bus_hs_wr_o), 32'd1);
    rst_i = 0;
    sb.delete();
    #1;
    checkOutput("midrst_ctrl", 32'({bus_hs_rd_o, bus_hs_wr_o, m0_ready_o, m1_ready_o}), 32'd0);
    checkOutput("midrst_addr", bus_hs_addr_o, 32'd0);
    checkOutput("midrst_data", bus_hs_data_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #4;
    rst_i = 1;
    @(posedge clk_i);
    #4;

    // Tie again after reset: m0 regains priority.
    lat_cfg = 1;
    applyStimulus(0, 0, 32'h0006_0004, 0, 0, 1);
`ifdef SPI_BUS_ARB_STICKY_EN
    applyStimulus(1, 0, 32'h0006_0008, 0, HOLD + 2, 0);
`else
    applyStimulus(1, 0, 32'h0006_0008, 0, 2, 0);
`endif
    waitDrain("postrst_drain", 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Two-master arbiter sharing the single handshake port to the interconnect (SPI controller at 0x60000) between the SPI boot controller (master 0) and the CPU data-side port (master 1). Grants whole transactions, round-robin on ties. Optionally keeps the grant with the current owner across back-to-back transactions so multi-access SPI sequences (inhibit, FIFO fill, release, drain) are not interleaved.

## Interface
- HOLD_CYCLES, 4: idle cycles an owner may keep a sticky grant between transactions (1..15).
- MAX_BURST, 64: maximum consecutive transactions per grant before forced release (1..255).
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- m0_rd_i / m0_wr_i  in  1  master 0 read / write request; held until m0_ready_o.
- m0_addr_i / m0_data_i  in  32  master 0 address / write data.
- m0_ready_o  out  1  master 0 transaction complete (one-cycle pulse).
- m0_data_o  out  32  master 0 read data, valid with m0_ready_o.
- m1_rd_i, m1_wr_i, m1_addr_i, m1_data_i, m1_ready_o, m1_data_o: same for master 1.
- bus_hs_rd_o / bus_hs_wr_o  out  1  read / write to interconnect.
- bus_hs_addr_o / bus_hs_data_o  out  32  address / write data to interconnect.
- bus_hs_ready_i  in  1  interconnect completion.
- bus_hs_data_i  in  32  interconnect read data.

## Operation
- Request of master n: mn_rd_i | mn_wr_i. Both rd and wr high from one master: wr wins on bus.
- Registers: state (IDLE, BUSY, HOLD), owner (1 bit), last_owner (1 bit), hold_cnt (4 bits), burst_cnt (8 bits).
- IDLE: bus outputs zero. One requester -> owner = it. Both -> owner = ~last_owner. Next BUSY, burst_cnt = 0.
- BUSY: bus_hs_* outputs = owner's rd/wr/addr/data combinationally; m<owner>_ready_o = bus_hs_ready_i; m<owner>_data_o = bus_hs_data_i; non-owner ready 0, data 0.
- BUSY, bus_hs_ready_i = 1: burst_cnt += 1. If sticky enabled and burst_cnt + 1 < MAX_BURST -> HOLD, hold_cnt = 0; else -> IDLE, last_owner = owner.
- BUSY, owner request drops without ready (protocol violation): -> IDLE next cycle, last_owner = owner, no ready issued.
- HOLD: bus outputs zero. Owner request -> BUSY (burst_cnt kept). Else hold_cnt += 1; hold_cnt == HOLD_CYCLES-1 -> IDLE, last_owner = owner. Non-owner requests ignored in HOLD.
- Non-owner request waits, never dropped; no ready to non-owner.
- Illegal state encoding -> IDLE.

## Timing
- Reset (asynchronous assert, any state): state IDLE, owner 0, last_owner 1 (master 0 wins first tie), counters 0; all outputs 0 immediately.
- Arbitration latency: request in cycle N (IDLE) -> bus request visible in cycle N+1.
- Sticky re-request: request in HOLD cycle N -> bus request visible in N+1.
- Ready is combinational pass-through: bus_hs_ready_i cycle N -> mn_ready_o cycle N.
- Owner returning to IDLE with other master requesting: other master on bus 2 cycles after release decision (IDLE cycle + grant).
- Simultaneous ready and new request from non-owner: completes owner transaction first; non-owner served after IDLE/HOLD rules.
- burst_cnt saturating not required: bounded by MAX_BURST release.

## Configuration
- SPI_BUS_ARB_STICKY_EN defined: HOLD state, hold_cnt, burst_cnt and MAX_BURST release active as above.
- Not defined: every completed transaction goes BUSY -> IDLE with last_owner updated; pure per-transaction round-robin; HOLD_CYCLES and MAX_BURST unused.

## Test plan
- Reset release, m0 write 0x60000 data 0x4, bus ready after 3 cycles -> bus_hs_wr_o high from cycle 1, m0_ready_o single pulse on ready cycle, outputs 0 after.
- m0 and m1 read simultaneously from IDLE after reset -> m0 granted first; m1 granted on the transaction after; next tie goes to m0 again.
- Sticky on: m0 issues 9 back-to-back writes to 0x60008 while m1 requests -> all 9 complete before m1 gets the bus; m1 granted after HOLD_CYCLES=4 idle cycles.
- Sticky on, MAX_BURST=4, m0 continuous requests, m1 pending -> m1 granted after m0's 4th ready.
- Sticky off, same stimulus -> grants alternate m0, m1, m0 per transaction.
- Assert rst_i low mid-transaction in BUSY -> all outputs 0 same cycle; after release, tie goes to m0.
